// File: rtl/mem_pkg.sv
// Shared definitions for the memory access stage: funct3 encodings, FSM state,
// access-size decode and store lane helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // Stores only know B/H; every other store encoding, and every unlisted load, is a word.
    function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
        size_e sz;
        sz = SZ_W;
        if (is_store) begin
            if (f3 == F3_B)      sz = SZ_B;
            else if (f3 == F3_H) sz = SZ_H;
        end else begin
            if (f3 == F3_B || f3 == F3_BU)      sz = SZ_B;
            else if (f3 == F3_H || f3 == F3_HU) sz = SZ_H;
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        return (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
    endfunction

    function automatic logic [3:0] store_be(input size_e sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns the addressed lane of a returned memory word to bit 0 and applies
// sign or zero extension according to the load funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] w_shifted;

    assign w_shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   data_o = {24'h0, w_shifted[7:0]};
            F3_HU:   data_o = {16'h0, w_shifted[15:0]};
            default: data_o = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: passes non-memory results through in one cycle, issues aligned
// loads/stores to the data memory, and aborts on misalignment or ack timeout.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_write_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  rd_o,
    output logic        reg_write_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam logic [7:0] LP_CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      r_state, w_nxt_state;
    logic [7:0]  r_cnt, w_nxt_cnt;
    logic        r_valid, w_nxt_valid;
    logic [31:0] r_wb_data, w_nxt_wb_data;
    logic [4:0]  r_rd, w_nxt_rd;
    logic        r_reg_write, w_nxt_reg_write;
    logic        r_misalign, w_nxt_misalign;
    logic        r_timeout, w_nxt_timeout;
    logic        r_req, w_nxt_req;
    logic        r_we, w_nxt_we;
    logic [31:0] r_addr, w_nxt_addr;
    logic [3:0]  r_be, w_nxt_be;
    logic [31:0] r_wdata, w_nxt_wdata;
    logic [2:0]  r_f3, w_nxt_f3;
    logic [1:0]  r_off, w_nxt_off;
    logic        r_store, w_nxt_store;
    logic [4:0]  r_op_rd, w_nxt_op_rd;
    logic        r_op_reg_write, w_nxt_op_reg_write;

    size_e       w_size;
    logic [31:0] w_load_data;

    load_extend u_load_extend (
        .rdata_i  (dmem_rdata_i),
        .offset_i (r_off),
        .funct3_i (r_f3),
        .data_o   (w_load_data)
    );

    assign w_size = access_size(funct3_i, mem_write_i);

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        w_nxt_state        = r_state;
        w_nxt_cnt          = r_cnt;
        w_nxt_valid        = 1'b0;
        w_nxt_wb_data      = r_wb_data;
        w_nxt_rd           = r_rd;
        w_nxt_reg_write    = r_reg_write;
        w_nxt_misalign     = 1'b0;
        w_nxt_timeout      = 1'b0;
        w_nxt_req          = r_req;
        w_nxt_we           = r_we;
        w_nxt_addr         = r_addr;
        w_nxt_be           = r_be;
        w_nxt_wdata        = r_wdata;
        w_nxt_f3           = r_f3;
        w_nxt_off          = r_off;
        w_nxt_store        = r_store;
        w_nxt_op_rd        = r_op_rd;
        w_nxt_op_reg_write = r_op_reg_write;

        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    w_nxt_rd = rd_i;
                    if (!(mem_read_i || mem_write_i)) begin
                        w_nxt_valid     = 1'b1;
                        w_nxt_wb_data   = addr_i;
                        w_nxt_reg_write = reg_write_i;
                    end else if (is_misaligned(w_size, addr_i[1:0])) begin
                        w_nxt_valid     = 1'b1;
                        w_nxt_misalign  = 1'b1;
                        w_nxt_wb_data   = 32'h0;
                        w_nxt_reg_write = 1'b0;
                    end else begin
                        w_nxt_state        = ST_ACCESS;
                        w_nxt_cnt          = 8'h0;
                        w_nxt_req          = 1'b1;
                        w_nxt_we           = mem_write_i;
                        w_nxt_addr         = {addr_i[31:2], 2'b00};
                        w_nxt_be           = mem_write_i ? store_be(w_size, addr_i[1:0]) : 4'b1111;
                        w_nxt_wdata        = store_data(w_size, wdata_i);
                        w_nxt_f3           = funct3_i;
                        w_nxt_off          = addr_i[1:0];
                        w_nxt_store        = mem_write_i;
                        w_nxt_op_rd        = rd_i;
                        w_nxt_op_reg_write = reg_write_i;
                    end
                end
            end
            ST_ACCESS: begin
                // Ack is tested first so a response on the last allowed cycle still completes.
                if (dmem_ack_i) begin
                    w_nxt_state     = ST_IDLE;
                    w_nxt_req       = 1'b0;
                    w_nxt_we        = 1'b0;
                    w_nxt_valid     = 1'b1;
                    w_nxt_rd        = r_op_rd;
                    w_nxt_wb_data   = r_store ? 32'h0 : w_load_data;
                    w_nxt_reg_write = r_store ? 1'b0 : r_op_reg_write;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_nxt_state     = ST_IDLE;
                    w_nxt_req       = 1'b0;
                    w_nxt_we        = 1'b0;
                    w_nxt_valid     = 1'b1;
                    w_nxt_timeout   = 1'b1;
                    w_nxt_rd        = r_op_rd;
                    w_nxt_wb_data   = 32'h0;
                    w_nxt_reg_write = 1'b0;
                end else begin
                    w_nxt_cnt = r_cnt + 8'h1;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_nxt_state;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt          <= 8'h0;
            r_valid        <= 1'b0;
            r_wb_data      <= 32'h0;
            r_rd           <= 5'h0;
            r_reg_write    <= 1'b0;
            r_misalign     <= 1'b0;
            r_timeout      <= 1'b0;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= 32'h0;
            r_be           <= 4'h0;
            r_wdata        <= 32'h0;
            r_f3           <= 3'h0;
            r_off          <= 2'h0;
            r_store        <= 1'b0;
            r_op_rd        <= 5'h0;
            r_op_reg_write <= 1'b0;
        end else begin
            r_cnt          <= w_nxt_cnt;
            r_valid        <= w_nxt_valid;
            r_wb_data      <= w_nxt_wb_data;
            r_rd           <= w_nxt_rd;
            r_reg_write    <= w_nxt_reg_write;
            r_misalign     <= w_nxt_misalign;
            r_timeout      <= w_nxt_timeout;
            r_req          <= w_nxt_req;
            r_we           <= w_nxt_we;
            r_addr         <= w_nxt_addr;
            r_be           <= w_nxt_be;
            r_wdata        <= w_nxt_wdata;
            r_f3           <= w_nxt_f3;
            r_off          <= w_nxt_off;
            r_store        <= w_nxt_store;
            r_op_rd        <= w_nxt_op_rd;
            r_op_reg_write <= w_nxt_op_reg_write;
        end
    end

    assign ready_o      = (r_state == ST_IDLE);
    assign valid_o      = r_valid;
    assign wb_data_o    = r_wb_data;
    assign rd_o         = r_rd;
    assign reg_write_o  = r_reg_write;
    assign misalign_o   = r_misalign;
    assign timeout_o    = r_timeout;
    assign dmem_req_o   = r_req;
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 4-cycle ack timeout; expected
// values are hand-computed constants.
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  rd_i;
    logic        reg_write_i;
    logic        ready_o, valid_o, reg_write_o, misalign_o, timeout_o;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.MEM_TIMEOUT(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rd_i         (rd_i),
        .reg_write_i  (reg_write_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .wb_data_o    (wb_data_o),
        .rd_o         (rd_o),
        .reg_write_o  (reg_write_o),
        .misalign_o   (misalign_o),
        .timeout_o    (timeout_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        valid_i     = 1'b1;
        mem_read_i  = rd_en;
        mem_write_i = wr_en;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
        rd_i        = rd;
        reg_write_i = 1'b1;
        tick();
        valid_i     = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
    endtask

    // Holds off ack for n-1 ACCESS cycles (request must stay up), acks on cycle n.
    task automatic ack_after(input string tag, input int n, input logic [31:0] rdata);
        for (int i = 1; i < n; i++) begin
            tick();
            check({tag, "_req_held"}, dmem_req_o, 1'b1);
        end
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
        tick();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        funct3_i = 3'h0; addr_i = 32'h0; wdata_i = 32'h0; rd_i = 5'h0; reg_write_i = 1'b0;
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        tick(); tick();
        check("rst_valid", valid_o, 1'b0);
        check("rst_req", dmem_req_o, 1'b0);
        check("rst_addr", dmem_addr_o, 32'h0);
        check("rst_wb", wb_data_o, 32'h0);
        rst_i = 1'b0;
        tick();
        check("rst_ready", ready_o, 1'b1);

        // Non-memory op, back to back with a second one
        valid_i = 1'b1; addr_i = 32'h1234; rd_i = 5'd5; reg_write_i = 1'b1;
        tick();
        check("nm_valid", valid_o, 1'b1);
        check("nm_wb", wb_data_o, 32'h1234);
        check("nm_rd", rd_o, 5'd5);
        check("nm_rw", reg_write_o, 1'b1);
        check("nm_ready", ready_o, 1'b1);
        addr_i = 32'hCAFE; rd_i = 5'd9;
        tick();
        check("nm2_valid", valid_o, 1'b1);
        check("nm2_wb", wb_data_o, 32'hCAFE);
        valid_i = 1'b0;
        tick();
        check("nm_pulse", valid_o, 1'b0);

        // LB 0x103, ack on third ACCESS cycle
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7);
        check("lb_ready", ready_o, 1'b0);
        check("lb_req", dmem_req_o, 1'b1);
        check("lb_addr", dmem_addr_o, 32'h100);
        check("lb_be", dmem_be_o, 4'b1111);
        check("lb_we", dmem_we_o, 1'b0);
        valid_i = 1'b1; addr_i = 32'h5555;   // ignored while in ACCESS
        ack_after("lb", 3, 32'h80FF_FF00);
        valid_i = 1'b0;
        check("lb_valid", valid_o, 1'b1);
        check("lb_data", wb_data_o, 32'hFFFF_FF80);
        check("lb_rd", rd_o, 5'd7);
        check("lb_rw", reg_write_o, 1'b1);
        check("lb_req_drop", dmem_req_o, 1'b0);
        check("lb_ready_back", ready_o, 1'b1);
        tick();
        check("lb_pulse", valid_o, 1'b0);

        // LBU same
        issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd8);
        ack_after("lbu", 3, 32'h80FF_FF00);
        check("lbu_data", wb_data_o, 32'h0000_0080);

        // LH / LHU upper half, unlisted load funct3 as LW
        issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd3);
        ack_after("lh", 1, 32'hBEEF_0000);
        check("lh_data", wb_data_o, 32'hFFFF_BEEF);
        issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd3);
        ack_after("lhu", 1, 32'hBEEF_0000);
        check("lhu_data", wb_data_o, 32'h0000_BEEF);
        issue(1'b1, 1'b0, 3'b011, 32'h300, 32'h0, 5'd4);
        ack_after("lw3", 2, 32'hDEAD_BEEF);
        check("lw3_data", wb_data_o, 32'hDEAD_BEEF);

        // SH 0x202
        issue(1'b0, 1'b1, 3'b001, 32'h202, 32'hABCD_1234, 5'd6);
        check("sh_be", dmem_be_o, 4'b1100);
        check("sh_wdata", dmem_wdata_o, 32'h1234_1234);
        check("sh_we", dmem_we_o, 1'b1);
        check("sh_addr", dmem_addr_o, 32'h200);
        ack_after("sh", 1, 32'hFFFF_FFFF);
        check("sh_valid", valid_o, 1'b1);
        check("sh_rw", reg_write_o, 1'b0);
        check("sh_wb", wb_data_o, 32'h0);

        // Read and write both set: store wins (SB 0x101)
        issue(1'b1, 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 5'd2);
        check("sb_we", dmem_we_o, 1'b1);
        check("sb_be", dmem_be_o, 4'b0010);
        check("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
        ack_after("sb", 1, 32'h0);
        check("sb_rw", reg_write_o, 1'b0);

        // Misaligned LW 0x301
        issue(1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 5'd1);
        check("mis_req", dmem_req_o, 1'b0);
        check("mis_valid", valid_o, 1'b1);
        check("mis_flag", misalign_o, 1'b1);
        check("mis_rw", reg_write_o, 1'b0);
        check("mis_ready", ready_o, 1'b1);
        tick();
        check("mis_req2", dmem_req_o, 1'b0);
        check("mis_pulse", misalign_o, 1'b0);

        // Timeout: request up 4 cycles, then abort
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd10);
        check("to_req1", dmem_req_o, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("to_req_n", dmem_req_o, 1'b1);
        end
        tick();
        check("to_req_drop", dmem_req_o, 1'b0);
        check("to_valid", valid_o, 1'b1);
        check("to_flag", timeout_o, 1'b1);
        check("to_rw", reg_write_o, 1'b0);
        check("to_ready", ready_o, 1'b1);
        tick();
        check("to_pulse", timeout_o, 1'b0);
        check("to_vpulse", valid_o, 1'b0);

        // Ack on the 4th cycle wins over timeout
        issue(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 5'd11);
        ack_after("ackw", 4, 32'h1357_9BDF);
        check("ackw_valid", valid_o, 1'b1);
        check("ackw_to", timeout_o, 1'b0);
        check("ackw_data", wb_data_o, 32'h1357_9BDF);
        check("ackw_rw", reg_write_o, 1'b1);

        // Reset mid-ACCESS
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd12);
        check("rm_req", dmem_req_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check("rm_req_now", dmem_req_o, 1'b0);
        check("rm_valid_now", valid_o, 1'b0);
        tick();
        rst_i = 1'b0;
        tick();
        check("rm_valid", valid_o, 1'b0);
        check("rm_ready", ready_o, 1'b1);
        check("rm_req_after", dmem_req_o, 1'b0);
        valid_i = 1'b1; addr_i = 32'h77; rd_i = 5'd13; reg_write_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("rm_recover", wb_data_o, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
